// File: rtl/vme_bus_arbiter.sv
// VME system-controller bus arbiter: BR/BG levels, BBSY tracking, BCLR, grant timeout.
// Latency: BR falling edge to BG falling edge is SYNC_STAGES+1 clocks; all outputs registered.
// No flow control; a grant waits for BBSY released. `define VME_ARB_ROUND_ROBIN_EN selects round-robin.
module vme_bus_arbiter #(
    parameter int LEVELS        = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int GRANT_TIMEOUT = 255
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [LEVELS-1:0]         vme_br,
    input  logic                      vme_bbsy,
    output logic [LEVELS-1:0]         vme_bgout,
    output logic                      vme_bclr,
    output logic [$clog2(LEVELS)-1:0] grant_level,
    output logic                      bus_owned,
    output logic                      grant_timeout
);
    localparam int LW = $clog2(LEVELS);
    localparam int CW = 10;

    typedef enum logic [1:0] {IDLE, GRANT, OWNED, RELEASE} state_t;

    logic [SYNC_STAGES-1:0][LEVELS-1:0] br_sync_q;
    logic [SYNC_STAGES-1:0]             bbsy_sync_q;
    logic [LEVELS-1:0]                  br_s;
    logic                               bbsy_s;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [LW-1:0]       gl_q, gl_d;
    logic [LEVELS-1:0]   bgout_q, bgout_d;
    logic                bclr_q, bclr_d;
    logic                owned_q, owned_d;
    logic                tmo_q, tmo_d;
    logic [LW-1:0]       win;
    logic                any_req;
`ifdef VME_ARB_ROUND_ROBIN_EN
    logic [LW-1:0]       ptr_q, ptr_d;
    int                  idx;
`else
    logic                hi_req;
`endif

    // Synchronise the asynchronous bus inputs; idle (high) out of reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            br_sync_q   <= '1;
            bbsy_sync_q <= '1;
        end else begin
            br_sync_q   <= {br_sync_q[SYNC_STAGES-2:0], vme_br};
            bbsy_sync_q <= {bbsy_sync_q[SYNC_STAGES-2:0], vme_bbsy};
        end
    end

    assign br_s   = br_sync_q[SYNC_STAGES-1];
    assign bbsy_s = bbsy_sync_q[SYNC_STAGES-1];

`ifdef VME_ARB_ROUND_ROBIN_EN
    // Round-robin winner: first requester after the last grant, wrapping; nearest candidate is applied last.
    always_comb begin
        win     = '0;
        idx     = 0;
        any_req = ~&br_s;
        for (int k = LEVELS; k >= 1; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= LEVELS) idx = idx - LEVELS;
            if (!br_s[idx]) win = LW'(idx);
        end
    end
`else
    // Fixed-priority winner (lowest index) and detection of a higher-priority requester for BCLR.
    always_comb begin
        win     = '0;
        hi_req  = 1'b0;
        any_req = ~&br_s;
        for (int i = LEVELS - 1; i >= 0; i--) begin
            if (!br_s[i]) win = LW'(i);
        end
        for (int i = 0; i < LEVELS; i++) begin
            if ((i < int'(gl_q)) && !br_s[i]) hi_req = 1'b1;
        end
    end
`endif

    // State and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gl_q    <= '0;
            bgout_q <= '1;
            bclr_q  <= 1'b1;
            owned_q <= 1'b0;
            tmo_q   <= 1'b0;
`ifdef VME_ARB_ROUND_ROBIN_EN
            ptr_q   <= LW'(LEVELS - 1);
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gl_q    <= gl_d;
            bgout_q <= bgout_d;
            bclr_q  <= bclr_d;
            owned_q <= owned_d;
            tmo_q   <= tmo_d;
`ifdef VME_ARB_ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    // Next state and next outputs; every output defaults to its inactive level.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gl_d    = gl_q;
        bgout_d = '1;
        bclr_d  = 1'b1;
        owned_d = 1'b0;
        tmo_d   = 1'b0;
`ifdef VME_ARB_ROUND_ROBIN_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                // Never grant while the bus is still busy.
                if (any_req && bbsy_s) begin
                    bgout_d[win] = 1'b0;
                    gl_d         = win;
                    cnt_d        = '0;
                    state_d      = GRANT;
`ifdef VME_ARB_ROUND_ROBIN_EN
                    ptr_d        = win;
`endif
                end
            end
            GRANT: begin
                // BBSY takes precedence over a simultaneous request withdrawal.
                if (!bbsy_s) begin
                    state_d = OWNED;
                    owned_d = 1'b1;
                end else if (br_s[gl_q]) begin
                    state_d = IDLE;
                end else if (cnt_q == CW'(GRANT_TIMEOUT - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    bgout_d = bgout_q;
                end
            end
            OWNED: begin
                if (bbsy_s) begin
                    state_d = RELEASE;
                end else begin
                    owned_d = 1'b1;
`ifndef VME_ARB_ROUND_ROBIN_EN
                    bclr_d  = ~hi_req;
`endif
                end
            end
            RELEASE: begin
                // Dead cycle guarantees a gap between successive grants.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign vme_bgout     = bgout_q;
    assign vme_bclr      = bclr_q;
    assign grant_level   = gl_q;
    assign bus_owned     = owned_q;
    assign grant_timeout = tmo_q;

endmodule
